// File: rtl/binarize_stage_pkg.sv
// Shared constants and types for the binarize stage: luma coefficients,
// pipeline depth, adaptive-threshold accumulator widths, divider length
// and the controller state encoding.
package binarize_stage_pkg;

    // Luma weights; they sum to 256, so (weighted sum >> 8) stays in 0..255
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // Registers between video_in and video_out
    localparam int PIPE_DEPTH = 3;

    // Per-frame luma sum and pixel count
    localparam int SUM_W = 32;
    localparam int CNT_W = 22;

    // One quotient bit per clock
    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } ctrl_state_t;

    // 8x8 unsigned product, widened so it can be summed without overflow
    function automatic logic [15:0] coef_mul(input logic [7:0] coef, input logic [7:0] chan);
        return {8'd0, coef} * {8'd0, chan};
    endfunction

endpackage

// File: rtl/binarize_stage_seq_div.sv
// Restoring unsigned divider, 32-bit dividend by 22-bit divisor.
// The first quotient bit is resolved on the start edge itself, so the
// whole quotient is ready after DIV_CYCLES clocks and o_done pulses once.
// Only built when ADAPTIVE_THRESH_EN is defined.
`ifdef ADAPTIVE_THRESH_EN
module seq_div
    import binarize_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [SUM_W-1:0]     i_dividend,
    input  logic [CNT_W-1:0]     i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SUM_W-1:0]     o_quotient
);

    // r_quo holds the not-yet-consumed dividend bits in its top and the
    // developed quotient bits in its bottom; after 32 shifts it is the quotient.
    logic [SUM_W-1:0] r_quo;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_dvs;
    logic [4:0]       r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [SUM_W-1:0] w_src_quo;
    logic [CNT_W-1:0] w_src_rem;
    logic [CNT_W-1:0] w_src_dvs;
    logic [CNT_W:0]   w_trial;
    logic             w_ge;
    logic [CNT_W-1:0] w_rem_next;

    // On the start edge the operands come straight from the inputs
    assign w_src_quo  = r_busy ? r_quo : i_dividend;
    assign w_src_rem  = r_busy ? r_rem : '0;
    assign w_src_dvs  = r_busy ? r_dvs : i_divisor;
    assign w_trial    = {w_src_rem, w_src_quo[SUM_W-1]};
    assign w_ge       = (w_trial >= {1'b0, w_src_dvs});
    // Remainder stays below the divisor, so the difference fits CNT_W bits
    assign w_rem_next = w_ge ? CNT_W'(w_trial - {1'b0, w_src_dvs}) : w_trial[CNT_W-1:0];

    // One shift-compare-subtract step per clock while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_quo  <= {w_src_quo[SUM_W-2:0], w_ge};
                r_rem  <= w_rem_next;
                r_dvs  <= i_divisor;
                r_cnt  <= 5'(DIV_CYCLES - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {w_src_quo[SUM_W-2:0], w_ge};
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule
`endif

// File: rtl/binarize_stage.sv
// Luma threshold binarizer: RGB -> Y -> black/white, 3-clock latency,
// syncs delayed to match. Optional macro ADAPTIVE_THRESH_EN replaces the
// static THRESHOLD with the mean luma of the previous frame.
module binarize_stage
    import binarize_stage_pkg::*;
#(
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] video_in,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [23:0] video_out,
    output logic [7:0]  thr_out
);

    logic [PIPE_DEPTH-1:0] r_de_pipe;
    logic [PIPE_DEPTH-1:0] r_hs_pipe;
    logic [PIPE_DEPTH-1:0] r_vs_pipe;

    logic [15:0] r_prod_r;
    logic [15:0] r_prod_g;
    logic [15:0] r_prod_b;
    logic [7:0]  r_y;
    logic [23:0] r_video;
    logic [7:0]  w_y;
    logic [7:0]  w_thr;

    // Sync/enable delay lines, one tap per pixel pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
        end else begin
            r_de_pipe <= {r_de_pipe[PIPE_DEPTH-2:0], de_in};
            r_hs_pipe <= {r_hs_pipe[PIPE_DEPTH-2:0], hsync_in};
            r_vs_pipe <= {r_vs_pipe[PIPE_DEPTH-2:0], vsync_in};
        end
    end

    // Stage 1: weighted channel products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
        end else begin
            r_prod_r <= coef_mul(COEF_R, video_in[23:16]);
            r_prod_g <= coef_mul(COEF_G, video_in[15:8]);
            r_prod_b <= coef_mul(COEF_B, video_in[7:0]);
        end
    end

    // Max sum is 256*255, so the 16-bit sum never wraps
    assign w_y = 8'((r_prod_r + r_prod_g + r_prod_b) >> 8);

    // Stage 2: luma
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_y;
        end
    end

    // Stage 3: compare against the threshold in force this clock; blank when de is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_video <= '0;
        end else begin
            r_video <= (r_de_pipe[1] && (r_y >= w_thr)) ? 24'hFFFFFF : 24'h000000;
        end
    end

`ifdef ADAPTIVE_THRESH_EN
    logic              r_vs_in_d;
    logic [SUM_W-1:0]  r_acc_sum;
    logic [CNT_W-1:0]  r_acc_cnt;
    ctrl_state_t       r_state;
    logic [7:0]        r_thr;

    logic              w_vs_rise;
    logic              w_capture;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [SUM_W-1:0]  w_quot;

    // A vsync edge seen mid-division is ignored: no capture, no clear
    assign w_vs_rise   = vsync_in & ~r_vs_in_d;
    assign w_capture   = w_vs_rise && (r_state == IDLE);
    assign w_div_start = w_capture && (r_acc_cnt != '0);

    // Per-frame luma sum/count from the stage-2 luma; capture restarts the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_in_d <= 1'b0;
            r_acc_sum <= '0;
            r_acc_cnt <= '0;
        end else begin
            r_vs_in_d <= vsync_in;
            if (w_capture) begin
                r_acc_sum <= r_de_pipe[1] ? SUM_W'(r_y) : '0;
                r_acc_cnt <= r_de_pipe[1] ? CNT_W'(1) : '0;
            end else if (r_de_pipe[1]) begin
                r_acc_sum <= r_acc_sum + SUM_W'(r_y);
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    // Divider samples the accumulators on the capture edge, before they clear
    seq_div u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (r_acc_sum),
        .i_divisor  (r_acc_cnt),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    // Controller: IDLE -> DIV (32 clk) -> LOAD -> IDLE; empty frames keep thr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_thr   <= THRESHOLD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_div_start) begin
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state <= LOAD;
                    end else if (!w_div_busy) begin
                        r_state <= IDLE;
                    end
                end
                LOAD: begin
                    // A mean of 8-bit values cannot exceed 255; clamp defensively
                    r_thr   <= (|w_quot[SUM_W-1:8]) ? 8'hFF : w_quot[7:0];
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_thr = r_thr;
`else
    assign w_thr = THRESHOLD;
`endif

    assign de_out    = r_de_pipe[PIPE_DEPTH-1];
    assign hsync_out = r_hs_pipe[PIPE_DEPTH-1];
    assign vsync_out = r_vs_pipe[PIPE_DEPTH-1];
    assign video_out = r_video;
    assign thr_out   = w_thr;

endmodule
